// File: rtl/iob_split_ctrl_if.sv
// IOb 1-to-N split bus bundle: initiator side plus flattened responder slices.
// The slave modport is the split controller's view; master drives it.
interface iob_split_ctrl_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32,
   parameter int N      = 2
);
   logic                    iob_avalid_i;
   logic [ADDR_W-1:0]       iob_addr_i;
   logic [DATA_W-1:0]       iob_wdata_i;
   logic [DATA_W/8-1:0]     iob_wstrb_i;
   logic                    iob_ready_o;
   logic                    iob_rvalid_o;
   logic [DATA_W-1:0]       iob_rdata_o;
   logic [N-1:0]            s_avalid_o;
   logic [N*ADDR_W-1:0]     s_addr_o;
   logic [N*DATA_W-1:0]     s_wdata_o;
   logic [N*DATA_W/8-1:0]   s_wstrb_o;
   logic [N-1:0]            s_ready_i;
   logic [N-1:0]            s_rvalid_i;
   logic [N*DATA_W-1:0]     s_rdata_i;

   modport slave (
      input  iob_avalid_i, iob_addr_i,
      input  iob_wdata_i, iob_wstrb_i,
      output iob_ready_o, iob_rvalid_o,
      output iob_rdata_o,
      output s_avalid_o, s_addr_o,
      output s_wdata_o, s_wstrb_o,
      input  s_ready_i, s_rvalid_i,
      input  s_rdata_i
   );

   modport master (
      output iob_avalid_i, iob_addr_i,
      output iob_wdata_i, iob_wstrb_i,
      input  iob_ready_o, iob_rvalid_o,
      input  iob_rdata_o,
      input  s_avalid_o, s_addr_o,
      input  s_wdata_o, s_wstrb_o,
      output s_ready_i, s_rvalid_i,
      output s_rdata_i
   );
endinterface

// File: rtl/iob_split_ctrl.sv
// IOb 1-to-N demultiplexer with in-order read return tracking.
// Out-of-range selects hit an internal null responder (index N).
module iob_split_ctrl #(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 32,
   parameter int N         = 2,
   parameter int SPLIT_PTR = ADDR_W - 2,
   parameter int MAX_OUT   = 4
) (
   input logic             clk_i,
   input logic             arst_i,
   input logic             cke_i,
   iob_split_ctrl_if.slave bus
);
   localparam int NBITS = $clog2(N) + ($clog2(N) == 0);
   localparam int SW    = NBITS + 1;
   localparam int CNT_W = $clog2(MAX_OUT + 1);
   localparam logic [SW-1:0]    NSEL = SW'(N);
   localparam logic [CNT_W-1:0] CMAX = CNT_W'(MAX_OUT);

   typedef enum logic {IDLE, PEND} state_t;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [SW-1:0]    rsel_q, rsel_d;
   logic             null_q, null_d;

   state_t           state;
   logic [SW-1:0]    sel;
   logic             stall;
   logic             rdy_sel;
   logic             rv_own;
   logic [DATA_W-1:0] rd_own;
   logic             read_acc;

   always_comb begin
      sel = '0;
      if (N > 1) begin
         sel = {1'b0, bus.iob_addr_i[SPLIT_PTR -: NBITS]};
      end
   end

   assign bus.s_addr_o  = {N{bus.iob_addr_i}};
   assign bus.s_wdata_o = {N{bus.iob_wdata_i}};
   assign bus.s_wstrb_o = {N{bus.iob_wstrb_i}};

   always_comb begin
      state   = (cnt_q == '0) ? IDLE : PEND;
      stall   = ((state == PEND) && (sel != rsel_q))
              || (cnt_q == CMAX);
      rdy_sel = 1'b1;
      rv_own  = 1'b0;
      rd_own  = '0;
      bus.s_avalid_o = '0;
      for (int k = 0; k < N; k++) begin
         if (sel == SW'(k)) begin
            rdy_sel = bus.s_ready_i[k];
            bus.s_avalid_o[k] = bus.iob_avalid_i & ~stall;
         end
         if (rsel_q == SW'(k)) begin
            rv_own = bus.s_rvalid_i[k];
            rd_own = bus.s_rdata_i[k*DATA_W +: DATA_W];
         end
      end
      // Null responder owns the reads: response is the 1-cycle flag.
      if (rsel_q >= NSEL) begin
         rv_own = null_q;
      end
      bus.iob_ready_o  = ~stall & rdy_sel;
      bus.iob_rvalid_o = (state == PEND) & rv_own;
      bus.iob_rdata_o  = rd_own;
      read_acc = bus.iob_avalid_i & bus.iob_ready_o
               & ~(|bus.iob_wstrb_i);
   end

   always_comb begin
      cnt_d  = cnt_q;
      rsel_d = rsel_q;
      null_d = read_acc & (sel >= NSEL);
      if (read_acc && !bus.iob_rvalid_o) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else if (!read_acc && bus.iob_rvalid_o) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
      if (read_acc) begin
         rsel_d = sel;
      end
   end

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         cnt_q  <= '0;
         rsel_q <= '0;
         null_q <= 1'b0;
      end else if (cke_i) begin
         cnt_q  <= cnt_d;
         rsel_q <= rsel_d;
         null_q <= null_d;
      end
   end
endmodule

// File: tb/tb_iob_split_ctrl.sv
// Bench for iob_split_ctrl (N=3, MAX_OUT=4, select field addr[6:5]).
// Queue-of-owners reference model plus directed literal checks.
module tb_iob_split_ctrl;
   localparam int DW = 32;
   localparam int AW = 8;
   localparam int NR = 3;

   logic clk = 1'b0;
   logic arst;
   logic cke;
   int   n_chk = 0;
   int   n_fail = 0;
   bit   chk_on = 1'b0;

   iob_split_ctrl_if #(.DATA_W(DW), .ADDR_W(AW), .N(NR)) bus ();

   iob_split_ctrl #(
      .DATA_W(DW), .ADDR_W(AW), .N(NR), .MAX_OUT(4)
   ) dut (
      .clk_i (clk),
      .arst_i(arst),
      .cke_i (cke),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Reference model: outstanding reads as a queue of owner indices.
   int q[$];
   bit null_p = 1'b0;
   bit u_valid = 1'b0;
   bit u_en, u_acc, u_pop;
   int u_sel;

   always @(negedge clk) begin : model_chk
      int s;
      bit stl, e_rdy, e_rv;
      logic [2:0] e_av;
      logic [31:0] e_rd;
      if (chk_on) begin
         if (arst) begin
            q.delete();
            null_p = 1'b0;
         end
         s = int'(bus.iob_addr_i[6:5]);
         stl = (q.size() != 0 && s != q[0]) || q.size() == 4;
         e_rdy = !stl && (s < NR ? bus.s_ready_i[s] : 1'b1);
         e_av = '0;
         if (bus.iob_avalid_i && !stl && s < NR) e_av[s] = 1'b1;
         e_rv = 1'b0;
         e_rd = '0;
         if (q.size() != 0) begin
            if (q[0] < NR) begin
               e_rv = bus.s_rvalid_i[q[0]];
               e_rd = bus.s_rdata_i[q[0]*DW +: DW];
            end else begin
               e_rv = null_p;
            end
         end
         chk("m_ready", 32'(bus.iob_ready_o), 32'(e_rdy));
         chk("m_avalid", 32'(bus.s_avalid_o), 32'(e_av));
         chk("m_rvalid", 32'(bus.iob_rvalid_o), 32'(e_rv));
         if (e_rv) chk("m_rdata", bus.iob_rdata_o, e_rd);
         chk("m_addr_bc", 32'(bus.s_addr_o),
             32'({3{bus.iob_addr_i}}));
         chk("m_wdata_bc2", bus.s_wdata_o[2*DW +: DW],
             bus.iob_wdata_i);
         chk("m_wstrb_bc", 32'(bus.s_wstrb_o),
             32'({3{bus.iob_wstrb_i}}));
         u_acc = bus.iob_avalid_i && e_rdy && bus.iob_wstrb_i == 0;
         u_sel = s;
         u_pop = e_rv;
         u_en = cke && !arst;
         u_valid = 1'b1;
      end
   end

   always @(posedge clk) begin
      if (u_valid && u_en) begin
         if (u_pop) void'(q.pop_front());
         if (u_acc) q.push_back(u_sel);
         null_p = u_acc && u_sel >= NR;
      end
      u_valid = 1'b0;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #3;
   endtask

   task automatic req(input bit v, input logic [7:0] a,
                      input logic [3:0] ws, input logic [2:0] rdy);
      bus.iob_avalid_i = v;
      bus.iob_addr_i   = a;
      bus.iob_wstrb_i  = ws;
      bus.s_ready_i    = rdy;
   endtask

   initial begin
      arst = 1'b1;
      cke  = 1'b1;
      bus.iob_wdata_i = 32'h1234_5678;
      bus.s_rvalid_i  = '0;
      bus.s_rdata_i   = {32'hC2C2_0002, 32'hC1C1_0001, 32'hC0C0_0000};
      req(1'b0, 8'h00, 4'h0, 3'b111);
      chk_on = 1'b1;
      settle();
      chk("rst_rvalid", 32'(bus.iob_rvalid_o), 32'd0);
      chk("rst_rdata", bus.iob_rdata_o, 32'hC0C0_0000);
      chk("rst_ready", 32'(bus.iob_ready_o), 32'd1);
      chk("rst_avalid", 32'(bus.s_avalid_o), 32'd0);
      step();
      arst = 1'b0;

      // write to responder 1, then write to 2 proves cnt stayed 0
      req(1'b1, 8'h20, 4'hF, 3'b010);
      settle();
      chk("wr1_avalid", 32'(bus.s_avalid_o), 32'b010);
      chk("wr1_ready", 32'(bus.iob_ready_o), 32'd1);
      step();
      req(1'b1, 8'h40, 4'hF, 3'b100);
      settle();
      chk("wr2_ready", 32'(bus.iob_ready_o), 32'd1);
      step();

      // read from 0, data returns 2 cycles later
      req(1'b1, 8'h00, 4'h0, 3'b001);
      settle();
      chk("rd0_ready", 32'(bus.iob_ready_o), 32'd1);
      step();
      bus.iob_avalid_i = 1'b0;
      step();
      step();
      bus.s_rvalid_i = 3'b001;
      bus.s_rdata_i[31:0] = 32'hCAFE_0001;
      settle();
      chk("rd0_rvalid", 32'(bus.iob_rvalid_o), 32'd1);
      chk("rd0_rdata", bus.iob_rdata_o, 32'hCAFE_0001);
      step();
      bus.s_rvalid_i = '0;
      settle();
      chk("rd0_done", 32'(bus.iob_rvalid_o), 32'd0);

      // pending read to 0 stalls a request to 1
      req(1'b1, 8'h00, 4'h0, 3'b011);
      step();
      req(1'b1, 8'h20, 4'hF, 3'b011);
      settle();
      chk("sw_stall_rdy", 32'(bus.iob_ready_o), 32'd0);
      chk("sw_stall_av", 32'(bus.s_avalid_o), 32'd0);
      step();
      bus.s_rvalid_i = 3'b001;
      settle();
      chk("sw_ret_rdy", 32'(bus.iob_ready_o), 32'd0);
      chk("sw_ret_rv", 32'(bus.iob_rvalid_o), 32'd1);
      step();
      bus.s_rvalid_i = '0;
      settle();
      chk("sw_go_rdy", 32'(bus.iob_ready_o), 32'd1);
      chk("sw_go_av", 32'(bus.s_avalid_o), 32'b010);
      step();

      // fill to MAX_OUT with reads to responder 1
      req(1'b1, 8'h20, 4'h0, 3'b010);
      for (int i = 0; i < 4; i++) begin
         settle();
         chk("fill_rdy", 32'(bus.iob_ready_o), 32'd1);
         step();
      end
      settle();
      chk("full_rdy", 32'(bus.iob_ready_o), 32'd0);
      step();
      bus.s_rvalid_i = 3'b010;
      settle();
      chk("full_rv_rdy", 32'(bus.iob_ready_o), 32'd0);
      chk("full_rv", 32'(bus.iob_rvalid_o), 32'd1);
      step();
      bus.s_rvalid_i = '0;
      settle();
      chk("fifth_rdy", 32'(bus.iob_ready_o), 32'd1);
      step();
      bus.iob_avalid_i = 1'b0;
      bus.s_rvalid_i = 3'b010;
      for (int i = 0; i < 4; i++) begin
         settle();
         chk("drain_rv", 32'(bus.iob_rvalid_o), 32'd1);
         step();
      end
      bus.s_rvalid_i = '0;
      settle();
      chk("drained_rv", 32'(bus.iob_rvalid_o), 32'd0);

      // out-of-range select: null responder
      req(1'b1, 8'h60, 4'h0, 3'b000);
      settle();
      chk("null_rdy", 32'(bus.iob_ready_o), 32'd1);
      chk("null_av", 32'(bus.s_avalid_o), 32'd0);
      step();
      bus.iob_avalid_i = 1'b0;
      settle();
      chk("null_rv", 32'(bus.iob_rvalid_o), 32'd1);
      chk("null_rdata", bus.iob_rdata_o, 32'd0);
      step();
      settle();
      chk("null_rv_end", 32'(bus.iob_rvalid_o), 32'd0);

      // reset with two reads pending drops their responses
      req(1'b1, 8'h00, 4'h0, 3'b001);
      step();
      step();
      bus.iob_avalid_i = 1'b0;
      arst = 1'b1;
      bus.s_rvalid_i = 3'b001;
      settle();
      chk("arst_rv", 32'(bus.iob_rvalid_o), 32'd0);
      step();
      arst = 1'b0;
      settle();
      chk("late_rv", 32'(bus.iob_rvalid_o), 32'd0);
      step();
      bus.s_rvalid_i = '0;

      // clock enable low: accepted read leaves cnt at 0
      cke = 1'b0;
      req(1'b1, 8'h00, 4'h0, 3'b001);
      settle();
      chk("cke_rdy", 32'(bus.iob_ready_o), 32'd1);
      step();
      cke = 1'b1;
      bus.iob_avalid_i = 1'b0;
      bus.s_rvalid_i = 3'b001;
      settle();
      chk("cke_hold_rv", 32'(bus.iob_rvalid_o), 32'd0);
      step();
      bus.s_rvalid_i = '0;

      for (int i = 0; i < 3000; i++) begin
         bus.iob_avalid_i = ($urandom % 4) != 0;
         bus.iob_addr_i   = 8'($urandom);
         bus.iob_wstrb_i  = ($urandom % 2) ? 4'h0 : 4'($urandom);
         bus.iob_wdata_i  = $urandom;
         bus.s_ready_i    = 3'($urandom);
         bus.s_rvalid_i   = ($urandom % 3 == 0) ? 3'($urandom) : 3'b0;
         bus.s_rdata_i    = {$urandom, $urandom, $urandom};
         cke  = ($urandom % 8) != 0;
         arst = ($urandom % 200) == 0;
         step();
      end
      arst = 1'b0;
      step();
      chk_on = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/iob_split_ctrl.md
Name: iob_split_ctrl

Overview:
- Demultiplexes one IOb initiator onto N IOb responders; the responder is chosen by an address field.
- Tracks outstanding reads so that rvalid/rdata return in order from the responder that owns them.
- Stalls the initiator when it targets a different responder while reads are still pending, or when the outstanding limit is reached.
- Sits between a CPU/bus initiator and peripheral groups. It is the fan-out counterpart of the N-to-1 IOb merge.

Parameters:
- DATA_W, 32, data width in bits (multiple of 8).
- ADDR_W, 32, address width.
- N, 2, number of responders (>=1).
- SPLIT_PTR, ADDR_W-2, MSB of the select field; field is addr[SPLIT_PTR -: NBITS], NBITS=$clog2(N)+($clog2(N)==0).
- MAX_OUT, 4, maximum outstanding reads (>=1); counter width CNT_W=$clog2(MAX_OUT+1).

Ports:
- clk_i  input  1  clock
- arst_i  input  1  asynchronous reset, active-high
- cke_i  input  1  clock enable; all registers hold when 0
- iob_avalid_i  input  1  initiator request valid
- iob_addr_i  input  ADDR_W  request address
- iob_wdata_i  input  DATA_W  write data
- iob_wstrb_i  input  DATA_W/8  byte strobes; all-zero means read
- iob_ready_o  output  1  request accepted this cycle when high with avalid
- iob_rvalid_o  output  1  read data valid
- iob_rdata_o  output  DATA_W  read data
- s_avalid_o  output  N  per-responder request valid
- s_addr_o  output  N*ADDR_W  address broadcast to every slice
- s_wdata_o  output  N*DATA_W  wdata broadcast
- s_wstrb_o  output  N*DATA_W/8  wstrb broadcast
- s_ready_i  input  N  per-responder ready
- s_rvalid_i  input  N  per-responder rvalid
- s_rdata_i  input  N*DATA_W  per-responder rdata, slice k at [k*DATA_W +: DATA_W]

Behaviour:
- sel = iob_addr_i[SPLIT_PTR -: NBITS]; forced to 0 when N=1.
- sel >= N is out-of-range and routes to the internal null responder (index N):
  - always ready; writes are dropped;
  - reads return rdata=0 with rvalid exactly 1 cycle after acceptance.
- Registers:
  - cnt (CNT_W), reset 0: outstanding reads.
  - resp_sel (NBITS+1), reset 0: owner of the outstanding reads.
  - null_rv (1), reset 0: pending null-responder read response.
- FSM state is IDLE when cnt==0 and PEND otherwise; no separate state register.
- stall = (cnt!=0 && sel!=resp_sel) || (cnt==MAX_OUT).
- Request path, combinational:
  - s_avalid_o[sel] = iob_avalid_i & ~stall; all other bits are 0.
  - iob_ready_o = ~stall & (sel<N ? s_ready_i[sel] : 1).
- Accept = iob_avalid_i & iob_ready_o. read_acc = accept & (iob_wstrb_i==0).
- Response path, combinational from resp_sel:
  - iob_rvalid_o = (cnt!=0) & (resp_sel<N ? s_rvalid_i[resp_sel] : null_rv).
  - iob_rdata_o = the resp_sel slice, or 0 for the null responder.
  - s_rvalid_i bits from non-owners are ignored.
- Updates on clk_i rising edge with cke_i=1:
  - cnt += read_acc - iob_rvalid_o. Simultaneous accept and return leaves cnt unchanged.
  - Underflow is impossible because rvalid is gated by cnt!=0.
  - resp_sel <= sel on read_acc; otherwise it holds.
  - null_rv <= read_acc & (sel>=N).
- Write accepts do not touch cnt. Writes to the owner proceed while reads are pending; writes to another responder stall while cnt!=0.
- Latency:
  - Request path has zero added cycles.
  - Response path has zero added cycles, plus 1 cycle for the null responder.
- At cnt==MAX_OUT with an rvalid in the same cycle, the stall still holds: ready is not combinationally released by rvalid.
- Reset mid-operation: cnt, resp_sel and null_rv clear immediately. iob_rvalid_o=0 and iob_ready_o follows the responder. Responses in flight from before reset are dropped.
- Reset values of outputs:
  - iob_rvalid_o=0, iob_rdata_o=s_rdata_i slice 0.
  - s_avalid_o and iob_ready_o are combinational, with stall=0.

Test Plan:
- Write to responder 1 (addr field=1, wstrb=4'hF, s_ready_i=2'b10) -> s_avalid_o=2'b10, iob_ready_o=1 in the same cycle; cnt stays 0.
- Read from responder 0, which returns rvalid 2 cycles later with rdata=32'hCAFE0001 -> iob_rvalid_o=1 and iob_rdata_o=32'hCAFE0001 in that cycle; cnt goes 0->1->0.
- Read from responder 0 pending, then a request to responder 1 -> iob_ready_o=0 and s_avalid_o=0 until responder 0 rvalid. The request is accepted the cycle after cnt returns to 0.
- MAX_OUT=4 back-to-back reads to responder 1 with no rvalid -> 4 accepts, then iob_ready_o=0. A 5th accept occurs only the cycle after the first rvalid.
- N=3, read with select field=3 -> accepted in 1 cycle; next cycle iob_rvalid_o=1, iob_rdata_o=0; s_avalid_o stays 3'b000.
- arst_i pulsed while cnt=2 -> cnt=0 and iob_rvalid_o=0. A subsequent late s_rvalid_i is not forwarded. With cke_i=0, cnt holds across an accepted read.
